// File: rtl/sd_emmc_axi_mem_responder.sv
// sd_emmc_axi_mem_responder: AXI4 INCR burst slave over a dual-port,
// byte-writable word memory with independent write and read channels.
module sd_emmc_axi_mem_responder #(
  parameter int          DEPTH     = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          IDX_W     = 12
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  output logic [15:0] wr_burst_cnt,
  output logic [15:0] rd_burst_cnt
);

  typedef enum logic [1:0] {W_ADDR, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_ADDR, R_FETCH, R_DATA} r_state_t;

  logic [31:0] mem [DEPTH];

  // Borrow bit of the 33-bit subtraction catches addresses below the base.
  function automatic logic in_rng(input logic [31:0] a);
    return (({1'b0, a} - {1'b0, BASE_ADDR}) >> (IDX_W + 2)) == 33'd0;
  endfunction

  function automatic logic [IDX_W-1:0] to_idx(input logic [31:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  w_state_t    w_state, w_next;
  logic [31:0] waddr;
  logic [7:0]  wlen;
  logic [8:0]  wbeat;
  logic        werr;
  logic        aw_hs, w_hs, b_hs, w_ok, w_bad_last;

  assign aw_hs      = awvalid & awready;
  assign w_hs       = wvalid & wready & ~reset;
  assign b_hs       = bvalid & bready;
  assign w_ok       = in_rng(waddr) && (wbeat <= {1'b0, wlen});
  assign w_bad_last = wlast && (wbeat != {1'b0, wlen});
  assign bresp      = (bvalid && werr) ? 2'b10 : 2'b00;

  always_ff @(posedge clock) begin
    if (reset) w_state <= W_ADDR;
    else       w_state <= w_next;
  end

  always_comb begin
    w_next  = w_state;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    unique case (w_state)
      W_ADDR: begin
        awready = 1'b1;
        if (awvalid) w_next = W_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid && wlast) w_next = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_next = W_ADDR;
      end
      default: w_next = W_ADDR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      waddr        <= '0;
      wlen         <= '0;
      wbeat        <= '0;
      werr         <= 1'b0;
      wr_burst_cnt <= '0;
    end else begin
      if (aw_hs) begin
        waddr <= awaddr;
        wlen  <= awlen;
        wbeat <= '0;
        werr  <= 1'b0;
      end
      if (w_hs) begin
        waddr <= waddr + 32'd4;
        if (wbeat != '1) wbeat <= wbeat + 9'd1;
        if (!w_ok || w_bad_last) werr <= 1'b1;
      end
      if (b_hs) wr_burst_cnt <= wr_burst_cnt + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_hs && w_ok) begin
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) mem[to_idx(waddr)][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  r_state_t    r_state, r_next;
  logic [31:0] raddr;
  logic [7:0]  rlen;
  logic [8:0]  rbeat;
  logic        ar_hs, r_hs, r_load;

  assign ar_hs  = arvalid & arready;
  assign r_hs   = rvalid & rready;
  assign r_load = (r_state == R_FETCH) || (r_hs && !rlast);

  always_ff @(posedge clock) begin
    if (reset) r_state <= R_ADDR;
    else       r_state <= r_next;
  end

  always_comb begin
    r_next  = r_state;
    arready = 1'b0;
    rvalid  = 1'b0;
    unique case (r_state)
      R_ADDR: begin
        arready = 1'b1;
        if (arvalid) r_next = R_FETCH;
      end
      R_FETCH: r_next = R_DATA;
      R_DATA: begin
        rvalid = 1'b1;
        if (rready && rlast) r_next = R_ADDR;
      end
      default: r_next = R_ADDR;
    endcase
  end

  // raddr/rbeat always point at the beat to be loaded next.
  always_ff @(posedge clock) begin
    if (reset) begin
      raddr        <= '0;
      rlen         <= '0;
      rbeat        <= '0;
      rdata        <= '0;
      rresp        <= '0;
      rlast        <= 1'b0;
      rd_burst_cnt <= '0;
    end else begin
      if (ar_hs) begin
        raddr <= araddr;
        rlen  <= arlen;
        rbeat <= '0;
      end
      if (r_load) begin
        rdata <= in_rng(raddr) ? mem[to_idx(raddr)] : 32'd0;
        rresp <= in_rng(raddr) ? 2'b00 : 2'b10;
        rlast <= (rbeat == {1'b0, rlen});
        raddr <= raddr + 32'd4;
        if (rbeat != '1) rbeat <= rbeat + 9'd1;
      end
      if (r_hs && rlast) begin
        rlast        <= 1'b0;
        rd_burst_cnt <= rd_burst_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_sd_emmc_axi_mem_responder.sv
// tb_sd_emmc_axi_mem_responder: scoreboard bench for the AXI memory
// responder; B and R beats are checked against queued expectations.
module tb_sd_emmc_axi_mem_responder;

  localparam int DEPTH = 4096;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [7:0]  awlen, arlen;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wlast, wvalid, wready;
  logic        bvalid, bready, arvalid, arready;
  logic        rlast, rvalid, rready;
  logic [1:0]  bresp, rresp;
  logic [15:0] wr_burst_cnt, rd_burst_cnt;

  always #5 clock = ~clock;

  sd_emmc_axi_mem_responder dut (
    .clock(clock), .reset(reset),
    .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready), .wr_burst_cnt(wr_burst_cnt),
    .rd_burst_cnt(rd_burst_cnt)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  int          wr_exp = 0;
  int          rd_exp = 0;
  logic [31:0] mm [int];
  logic [1:0]  bq [$];
  logic [34:0] rq [$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic in_rng(input logic [31:0] a);
    return (a >> 2) < DEPTH;
  endfunction

  always @(negedge clock) begin
    if (!reset && bvalid && bready) begin
      if (bq.size() == 0) chk("b_unexpected", 64'(bvalid), 64'd0);
      else chk("bresp", 64'(bresp), 64'(bq.pop_front()));
    end
    if (!reset && rvalid && rready) begin
      if (rq.size() == 0) chk("r_unexpected", 64'(rvalid), 64'd0);
      else chk("rbeat", 64'({rdata, rresp, rlast}), 64'(rq.pop_front()));
    end
  end

  task automatic wr_burst(input logic [31:0] a, input int len, input int nb,
                          input logic [3:0] strb, input logic [31:0] d0);
    logic        err;
    logic [31:0] ab, dv, w;
    int          n;
    err = (nb - 1) != len;
    for (int b = 0; b < nb; b++) begin
      ab = a + 32'(4 * b);
      dv = d0 + 32'(b);
      if (b <= len && in_rng(ab)) begin
        w = mm.exists(int'(ab >> 2)) ? mm[int'(ab >> 2)] : 32'd0;
        for (int y = 0; y < 4; y++)
          if (strb[y]) w[8*y +: 8] = dv[8*y +: 8];
        mm[int'(ab >> 2)] = w;
      end else begin
        err = 1'b1;
      end
    end
    bq.push_back(err ? 2'b10 : 2'b00);
    awaddr = a; awlen = 8'(len); awvalid = 1'b1;
    n = 0;
    while (!awready && n < 20) begin tick(); n++; end
    chk("awready", 64'(awready), 64'd1);
    tick();
    awvalid = 1'b0;
    for (int b = 0; b < nb; b++) begin
      wdata = d0 + 32'(b); wstrb = strb;
      wlast = (b == nb - 1); wvalid = 1'b1;
      n = 0;
      while (!wready && n < 20) begin tick(); n++; end
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("bvalid_next", 64'(bvalid), 64'd1);
    n = 0;
    while (bq.size() > 0 && n < 20) begin tick(); n++; end
    chk("b_left", 64'(bq.size()), 64'd0);
    bq.delete();
    wr_exp++;
    chk("wr_cnt", 64'(wr_burst_cnt), 64'(wr_exp));
  endtask

  task automatic rd_burst(input logic [31:0] a, input int len, input logic tog);
    logic [31:0] ab, dv;
    int          n;
    for (int b = 0; b <= len; b++) begin
      ab = a + 32'(4 * b);
      dv = (in_rng(ab) && mm.exists(int'(ab >> 2))) ? mm[int'(ab >> 2)] : 32'd0;
      rq.push_back({dv, in_rng(ab) ? 2'b00 : 2'b10, 1'(b == len)});
    end
    araddr = a; arlen = 8'(len); arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!arready && n < 20) begin tick(); n++; end
    chk("arready", 64'(arready), 64'd1);
    tick();
    arvalid = 1'b0;
    chk("rvalid_fetch", 64'(rvalid), 64'd0);
    tick();
    chk("rvalid_2edge", 64'(rvalid), 64'd1);
    n = 0;
    while (rq.size() > 0 && n < 600) begin
      if (tog) rready = ~rready;
      tick();
      n++;
    end
    rready = 1'b1;
    if (!tog) chk("r_stream", 64'(n), 64'(len + 1));
    chk("r_left", 64'(rq.size()), 64'd0);
    rq.delete();
    rd_exp++;
    chk("rd_cnt", 64'(rd_burst_cnt), 64'(rd_exp));
    chk("rvalid_idle", 64'(rvalid), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    awaddr = '0; awlen = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b1;
    repeat (3) tick();
    chk("rst_awready", 64'(awready), 64'd1);
    chk("rst_arready", 64'(arready), 64'd1);
    chk("rst_outs", 64'({wready, bvalid, bresp, rvalid, rlast, rresp}), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_cnts", 64'({wr_burst_cnt, rd_burst_cnt}), 64'd0);
    reset = 1'b0;
    tick();

    wr_burst(32'h100, 15, 16, 4'hF, 32'd0);
    rd_burst(32'h100, 15, 1'b0);

    wr_burst(32'h200, 0, 1, 4'hF, 32'h1122_3344);
    wr_burst(32'h200, 0, 1, 4'b0101, 32'hAABB_CCDD);
    rd_burst(32'h200, 0, 1'b0);

    wr_burst(32'((DEPTH - 2) * 4), 1, 2, 4'hF, 32'hCAFE_0000);
    rd_burst(32'((DEPTH - 2) * 4), 3, 1'b0);

    wr_burst(32'h400, 7, 4, 4'hF, 32'h0000_0500);
    rd_burst(32'h400, 3, 1'b1);
    rd_burst(32'h100, 15, 1'b1);

    wr_burst(32'((DEPTH - 1) * 4), 1, 2, 4'hF, 32'h0000_0077);

    fork
      wr_burst(32'h800, 3, 4, 4'hF, 32'h0000_0900);
      rd_burst(32'h100, 3, 1'b0);
    join
    rd_burst(32'h800, 3, 1'b0);

    awaddr = 32'h600; awlen = 8'd7; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    wdata = 32'h1234; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    tick();
    wvalid = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    chk("mid_awready", 64'(awready), 64'd1);
    chk("mid_arready", 64'(arready), 64'd1);
    chk("mid_bvalid", 64'(bvalid), 64'd0);
    chk("mid_cnts", 64'({wr_burst_cnt, rd_burst_cnt}), 64'd0);
    reset = 1'b0;
    wr_exp = 0;
    rd_exp = 0;
    tick();
    chk("post_bvalid", 64'(bvalid), 64'd0);
    wr_burst(32'h700, 15, 16, 4'hF, 32'd100);
    rd_burst(32'h700, 15, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
